// File: rtl/oc8051_priv_pkg.sv
// Shared constants for the 8051 privilege tracker: fault codes and the user level.
package oc8051_priv_pkg;

    typedef enum logic [1:0] {
        PRIV_F_NONE = 2'd0,
        PRIV_F_OVF  = 2'd1,
        PRIV_F_UNF  = 2'd2,
        PRIV_F_ILL  = 2'd3
    } priv_fault_e;

    localparam int unsigned PRIV_USER = 0;

endpackage

// File: rtl/oc8051_priv_lifo.sv
// Privilege-level LIFO with a registered top-of-stack, entry count and full/empty flags.
module oc8051_priv_lifo #(
    parameter int DEPTH = 16,
    parameter int LVL_W = 2,
    parameter int DP_W  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [LVL_W-1:0] din,
    output logic [LVL_W-1:0] top,
    output logic [DP_W-1:0]  count,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [LVL_W-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    below_idx;

    assign full      = (count == DP_W'(DEPTH));
    assign empty     = (count == '0);
    assign do_pop    = pop && !empty;
    assign do_push   = push && !full && !pop;
    assign wr_idx    = AW'(count);
    // Entry that becomes the new top after a pop (only read when count >= 2).
    assign below_idx = AW'(count - DP_W'(2));

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_idx] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            top   <= '0;
        end else if (do_pop) begin
            count <= count - DP_W'(1);
            top   <= (count >= DP_W'(2)) ? mem[below_idx] : '0;
        end else if (do_push) begin
            count <= count + DP_W'(1);
            top   <= din;
        end
    end

endmodule

// File: rtl/oc8051_priv_stack.sv
// Nested privilege tracker: arbitrates enter/leave strobes, checks legality and
// keeps a sticky first-fault record for the boot monitor.
module oc8051_priv_stack
    import oc8051_priv_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int LVL_W = 2,
    parameter int DP_W  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enter_req,
    input  logic [LVL_W-1:0] enter_lvl,
    input  logic             leave_req,
    input  logic             fault_clr,
    output logic [LVL_W-1:0] priv_lvl,
    output logic             su_mode,
    output logic [DP_W-1:0]  depth,
    output logic             fault,
    output logic [1:0]       fault_code,
    output logic             fault_pulse
);

    logic        full;
    logic        empty;
    logic        push;
    logic        unf;
    logic        ill;
    logic        ovf;
    logic        reject;
    priv_fault_e new_code;
    priv_fault_e code_q;

    oc8051_priv_lifo #(
        .DEPTH (DEPTH),
        .LVL_W (LVL_W),
        .DP_W  (DP_W)
    ) u_lifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (leave_req),
        .din   (enter_lvl),
        .top   (priv_lvl),
        .count (depth),
        .full  (full),
        .empty (empty)
    );

    // Leave wins over enter; a set fault locks out further escalation.
    always_comb begin
        unf  = leave_req && empty;
        ill  = 1'b0;
        ovf  = 1'b0;
        push = 1'b0;
        if (enter_req && !leave_req && !fault) begin
            if (enter_lvl < priv_lvl) begin
                ill = 1'b1;
            end else if (full) begin
                ovf = 1'b1;
            end else begin
                push = 1'b1;
            end
        end
        reject   = unf || ill || ovf;
        new_code = unf ? PRIV_F_UNF :
                   ill ? PRIV_F_ILL :
                   ovf ? PRIV_F_OVF : PRIV_F_NONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fault       <= 1'b0;
            code_q      <= PRIV_F_NONE;
            fault_pulse <= 1'b0;
        end else begin
            fault_pulse <= reject;
            if (reject) begin
                fault <= 1'b1;
                if (fault_clr || code_q == PRIV_F_NONE) begin
                    code_q <= new_code;
                end
            end else if (fault_clr) begin
                fault  <= 1'b0;
                code_q <= PRIV_F_NONE;
            end
        end
    end

    assign fault_code = code_q;
    assign su_mode    = (priv_lvl != LVL_W'(PRIV_USER));

endmodule

// File: tb/tb_oc8051_priv_stack.sv
// Self-checking bench: queue-based reference model compared every cycle, plus
// directed sequences with literal expectations and a randomized phase.
module tb_oc8051_priv_stack;

    localparam int DEPTH = 16;
    localparam int LVL_W = 2;
    localparam int DP_W  = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             enter_req;
    logic [LVL_W-1:0] enter_lvl;
    logic             leave_req;
    logic             fault_clr;
    logic [LVL_W-1:0] priv_lvl;
    logic             su_mode;
    logic [DP_W-1:0]  depth;
    logic             fault;
    logic [1:0]       fault_code;
    logic             fault_pulse;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    oc8051_priv_stack #(
        .DEPTH (DEPTH),
        .LVL_W (LVL_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enter_req   (enter_req),
        .enter_lvl   (enter_lvl),
        .leave_req   (leave_req),
        .fault_clr   (fault_clr),
        .priv_lvl    (priv_lvl),
        .su_mode     (su_mode),
        .depth       (depth),
        .fault       (fault),
        .fault_code  (fault_code),
        .fault_pulse (fault_pulse)
    );

    always #5 clk = ~clk;

    // Reference model: the stack is a plain queue of levels.
    int m_stk[$];
    int m_fault = 0;
    int m_code  = 0;
    int m_pulse = 0;

    always @(posedge clk) begin
        int rej;
        int code;
        int cur;
        if (rst) begin
            m_stk.delete();
            m_fault = 0;
            m_code  = 0;
            m_pulse = 0;
        end else begin
            rej  = 0;
            code = 0;
            cur  = (m_stk.size() > 0) ? m_stk[$] : 0;
            if (leave_req) begin
                if (m_stk.size() > 0) void'(m_stk.pop_back());
                else begin rej = 1; code = 2; end
            end else if (enter_req && m_fault == 0) begin
                if (int'(enter_lvl) < cur) begin rej = 1; code = 3; end
                else if (m_stk.size() == DEPTH) begin rej = 1; code = 1; end
                else m_stk.push_back(int'(enter_lvl));
            end
            m_pulse = rej;
            if (fault_clr) begin m_fault = 0; m_code = 0; end
            if (rej != 0) begin
                m_fault = 1;
                if (m_code == 0) m_code = code;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        int mlvl;
        if (check_en) begin
            mlvl = (m_stk.size() > 0) ? m_stk[$] : 0;
            check("model.priv_lvl",    32'(priv_lvl),    32'(mlvl));
            check("model.su_mode",     32'(su_mode),     32'(mlvl != 0));
            check("model.depth",       32'(depth),       32'(m_stk.size()));
            check("model.fault",       32'(fault),       32'(m_fault));
            check("model.fault_code",  32'(fault_code),  32'(m_code));
            check("model.fault_pulse", 32'(fault_pulse), 32'(m_pulse));
        end
    end

    // Drive one cycle of inputs; returns after the following negedge.
    task automatic cyc(input bit r, input bit e, input int lvl, input bit l, input bit c);
        rst       = r;
        enter_req = e;
        enter_lvl = LVL_W'(lvl);
        leave_req = l;
        fault_clr = c;
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0);
    endtask

    initial begin
        int exp_push[4];
        int exp_pop[4];
        exp_push = '{1, 2, 2, 3};
        exp_pop  = '{2, 2, 1, 0};

        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        check_en = 1'b1;
        check("reset.depth", 32'(depth), 0);
        check("reset.priv_lvl", 32'(priv_lvl), 0);
        check("reset.fault", 32'(fault), 0);
        check("reset.fault_code", 32'(fault_code), 0);

        // Nested push/pop ordering.
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, exp_push[i], 0, 0);
            check("nest.push_lvl", 32'(priv_lvl), 32'(exp_push[i]));
            check("nest.push_depth", 32'(depth), 32'(i + 1));
        end
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 1, 0);
            check("nest.pop_lvl", 32'(priv_lvl), 32'(exp_pop[i]));
            check("nest.pop_depth", 32'(depth), 32'(3 - i));
            check("nest.su_mode", 32'(su_mode), 32'(i < 3));
        end

        // Overflow on the 17th push.
        for (int i = 0; i < DEPTH; i++) cyc(0, 1, 1, 0, 0);
        check("ovf.full_depth", 32'(depth), 32'(DEPTH));
        check("ovf.no_fault_yet", 32'(fault), 0);
        cyc(0, 1, 1, 0, 0);
        check("ovf.fault", 32'(fault), 1);
        check("ovf.code", 32'(fault_code), 1);
        check("ovf.pulse", 32'(fault_pulse), 1);
        check("ovf.depth_held", 32'(depth), 32'(DEPTH));
        idle();
        check("ovf.pulse_one_cycle", 32'(fault_pulse), 0);

        // Underflow, lock-out, clear.
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        check("unf.code", 32'(fault_code), 2);
        check("unf.depth", 32'(depth), 0);
        cyc(0, 1, 1, 0, 0);
        check("lock.depth", 32'(depth), 0);
        check("lock.no_pulse", 32'(fault_pulse), 0);
        cyc(0, 0, 0, 0, 1);
        check("clr.fault", 32'(fault), 0);
        cyc(0, 1, 1, 0, 0);
        check("clr.push_depth", 32'(depth), 1);

        // Illegal demotion, then unwind while faulted.
        cyc(0, 1, 3, 0, 0);
        cyc(0, 1, 1, 0, 0);
        check("ill.code", 32'(fault_code), 3);
        check("ill.lvl_held", 32'(priv_lvl), 3);
        cyc(0, 0, 0, 1, 0);
        check("ill.unwind_lvl", 32'(priv_lvl), 1);
        check("ill.fault_sticky", 32'(fault), 1);

        // Simultaneous enter and leave: leave only.
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 0);
        cyc(0, 1, 1, 0, 0);
        cyc(0, 1, 3, 1, 0);
        check("both.depth", 32'(depth), 1);
        check("both.fault", 32'(fault), 0);
        check("both.pulse", 32'(fault_pulse), 0);

        // Clear coincident with underflow: new fault wins.
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 1);
        check("clrunf.fault", 32'(fault), 1);
        check("clrunf.code", 32'(fault_code), 2);

        // Reset at depth 5 with fault set.
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 1, 1, 0, 0);
        cyc(0, 1, 0, 0, 0);
        check("rst5.depth_before", 32'(depth), 5);
        check("rst5.fault_before", 32'(fault), 1);
        cyc(1, 1, 2, 0, 1);
        check("rst5.depth", 32'(depth), 0);
        check("rst5.priv_lvl", 32'(priv_lvl), 0);
        check("rst5.su_mode", 32'(su_mode), 0);
        check("rst5.fault", 32'(fault), 0);
        check("rst5.fault_code", 32'(fault_code), 0);
        check("rst5.fault_pulse", 32'(fault_pulse), 0);

        // Randomized phase; leaves are less frequent so the stack fills up.
        for (int i = 0; i < 4000; i++) begin
            cyc($urandom_range(0, 149) == 0,
                $urandom_range(0, 99) < 55,
                int'($urandom_range(0, 3)),
                $urandom_range(0, 99) < 35,
                $urandom_range(0, 29) == 0);
        end

        idle();
        check_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/oc8051_priv_stack.md
# oc8051_priv_stack

Parametrised privilege tracker for the secure-boot 8051 core. It replaces the single-bit nesting counter with a LIFO of privilege levels, so nested supervisor calls can enter different levels and unwind in order. It reports nesting depth and detects overflow, underflow and illegal demotion as a sticky fault for the boot monitor. It sits beside the decoder and receives the same enter/leave strobes.

## Interface
- DEPTH, 16: maximum nesting depth; at least 2.
- LVL_W, 2: privilege level width. Level 0 is user; higher values are more privileged.
- DP_W, $clog2(DEPTH+1): width of the depth output (derived; do not override).

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- enter_req  in  1  push request; one-cycle strobe
- enter_lvl  in  LVL_W  target level for enter_req
- leave_req  in  1  pop request; one-cycle strobe
- fault_clr  in  1  clears the sticky fault
- priv_lvl  out  LVL_W  current level: top of stack, or 0 when empty
- su_mode  out  1  high when priv_lvl != 0
- depth  out  DP_W  number of valid stack entries
- fault  out  1  sticky fault flag
- fault_code  out  2  first fault since last clear: 0 none, 1 OVF, 2 UNF, 3 ILL
- fault_pulse  out  1  one-cycle pulse on every rejected request

## Operation
- Reset values: depth=0, priv_lvl=0, su_mode=0, fault=0, fault_code=0, fault_pulse=0. The stack contents are don't-care.
- leave_req has priority. If enter_req and leave_req are both high, only the leave is processed; the enter is dropped silently with no fault.
- leave_req:
  - depth>0: pop, depth-1, priv_lvl becomes the new top (0 if the stack is now empty).
  - depth==0: UNF fault, no state change.
- enter_req (without leave_req):
  - Fault already set: the request is ignored with no new pulse. This locks the tracker against escalation until the fault is cleared.
  - enter_lvl < priv_lvl: ILL fault, no push.
  - depth==DEPTH: OVF fault, no push.
  - Otherwise: push enter_lvl, depth+1. Pushing the same level as the current one is legal.
- Leave requests are still processed while fault is set, so software can unwind.
- A rejected request drives fault_pulse high for one cycle and sets fault. fault_code is written only if it is currently 0.
- fault_clr resets fault and fault_code to 0. If a new fault occurs in the same cycle as fault_clr, the new fault wins: fault=1 and fault_code is the new code.
- su_mode is derived from the registered priv_lvl. It stays 0 while depth>0 if every pushed level is 0.
- depth arithmetic is unsigned and never wraps; the OVF and UNF guards make it saturate.

## Timing
- All outputs are registered. The effect of a request accepted at clock edge N is visible after edge N; there is no combinational path from inputs to outputs.
- Back-to-back strobes are allowed every cycle; throughput is one operation per cycle.
- rst asserted mid-sequence empties the stack on the next edge. It overrides every request and fault_clr in the same cycle.
- fault_pulse is high for exactly the cycle after the rejecting edge.

## Structure
- Package oc8051_priv_pkg holds:
  - fault code constants: PRIV_F_NONE, PRIV_F_OVF, PRIV_F_UNF, PRIV_F_ILL
  - the level-0 constant PRIV_USER
- Sub-module oc8051_priv_lifo (parametrised by DEPTH and LVL_W) provides:
  - storage, push, pop, count and top-of-stack register
  - full and empty flags
- The top level owns the request arbitration, the legality check and the fault logic.

## Test plan
- After reset, push levels 1, 2, 2, 3 on consecutive cycles, then issue 4 leaves. Expect priv_lvl 1, 2, 2, 3 then 2, 2, 1, 0; depth 1..4 then 3..0; su_mode falls only after the last leave.
- With DEPTH=16, issue 17 pushes of level 1. Expect depth=16, then fault=1, fault_code=1 and a single-cycle fault_pulse on the 17th push.
- From reset, issue leave_req. Expect fault_code=2, depth stays 0. Then push level 1: it is ignored while fault=1. Pulse fault_clr and push level 1 again: expect depth=1.
- At priv_lvl=3, push level 1. Expect fault_code=3 and priv_lvl stays 3. Then issue leave: expect priv_lvl drops to the prior level even though fault is still set.
- At depth=2, assert enter_req (level 3) and leave_req together. Expect depth=1, no fault, no pulse.
- Assert fault_clr in the same cycle as an underflow. Expect fault=1, fault_code=2. Assert rst with depth=5 and fault set: next cycle all outputs are 0.
